seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 158 +++++++++++++++
 tb/tb_seq_alu.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/add/compare ops plus iterative shift-add
// multiply and restoring divide, with an IDLE/BUSY/DONE handshake.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
        OP_XOR = 4'd4, OP_NOR = 4'd5, OP_SLT = 4'd6, OP_SLTU = 4'd7
    } op_t;

    state_t             state;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH:0]     div_tmp;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quot_next;
    logic [WIDTH-1:0]   iter_res;

    // Single-cycle ops work straight from the ports; they are only used on the accepting edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                alu_res = a + b;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = a - b;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_res = '0;
        endcase
    end

    // One iteration step; a zero divisor naturally yields all-ones quotient and remainder = a.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opa} : '0);
        prod_next = {mul_sum, prod[WIDTH-1:1]};
        div_tmp   = {rem, quot[WIDTH-1]};
        div_diff  = div_tmp - {1'b0, opb};
        div_ge    = div_tmp >= {1'b0, opb};
        rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0];
        quot_next = {quot[WIDTH-2:0], div_ge};
        if (op_q[1])
            iter_res = op_q[0] ? rem_next : quot_next;
        else
            iter_res = op_q[0] ? prod_next[2*WIDTH-1:WIDTH] : prod_next[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready       <= 1'b1;
            valid       <= 1'b0;
            result      <= '0;
            zero        <= 1'b1;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            op_q        <= '0;
            opa         <= '0;
            opb         <= '0;
            prod        <= '0;
            quot        <= '0;
            rem         <= '0;
            count       <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start && op[3:2] == 2'b10) begin
                        state <= BUSY;
                        ready <= 1'b0;
                        op_q  <= op;
                        opa   <= a;
                        opb   <= b;
                        prod  <= {{WIDTH{1'b0}}, b};
                        quot  <= a;
                        rem   <= '0;
                        count <= '0;
                    end else if (start) begin
                        state       <= DONE;
                        ready       <= 1'b1;
                        valid       <= 1'b1;
                        result      <= alu_res;
                        zero        <= (alu_res == '0);
                        overflow    <= alu_ovf;
                        div_by_zero <= 1'b0;
                    end else begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                BUSY: begin
                    if (op_q[1]) begin
                        rem  <= rem_next;
                        quot <= quot_next;
                    end else begin
                        prod <= prod_next;
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state       <= DONE;
                        ready       <= 1'b1;
                        valid       <= 1'b1;
                        result      <= iter_res;
                        zero        <= (iter_res == '0);
                        overflow    <= 1'b0;
                        div_by_zero <= op_q[1] && (opb == '0);
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed corner cases plus
// randomized ops compared against a plain-arithmetic reference model.
module tb_seq_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    op = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          ready;
    logic          valid;
    logic [W-1:0]  result;
    logic          zero;
    logic          overflow;
    logic          div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .valid(valid), .result(result), .zero(zero),
        .overflow(overflow), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic v, output logic d,
                                  output int lat);
        longint s;
        logic [63:0] p;
        r = '0; v = 1'b0; d = 1'b0;
        p = 64'(x) * 64'(y);
        lat = (o >= 8 && o <= 11) ? W + 1 : 1;
        case (o)
            0: begin
                s = longint'($signed(x)) + longint'($signed(y));
                r = x + y;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            1: begin
                s = longint'($signed(x)) - longint'($signed(y));
                r = x - y;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2:  r = x & y;
            3:  r = x | y;
            4:  r = x ^ y;
            5:  r = ~(x | y);
            6:  r = ($signed(x) < $signed(y)) ? 1 : 0;
            7:  r = (x < y) ? 1 : 0;
            8:  r = p[31:0];
            9:  r = p[63:32];
            10: begin r = (y == 0) ? '1 : x / y; d = (y == 0); end
            11: begin r = (y == 0) ? x : x % y; d = (y == 0); end
            default: r = '0;
        endcase
    endfunction

    task automatic check_outputs(input string tag, input logic [3:0] o,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        logic v, d;
        int lat;
        model(o, x, y, r, v, d, lat);
        check({tag, "_valid"}, 64'(valid), 64'(1));
        check({tag, "_result"}, 64'(result), 64'(r));
        check({tag, "_zero"}, 64'(zero), 64'(r == 0));
        check({tag, "_ovf"}, 64'(overflow), 64'(v));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(d));
    endtask

    // Issue one op, optionally jiggling inputs and start while busy, then check latency and outputs.
    task automatic do_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit noise);
        logic [W-1:0] r;
        logic v, d;
        int exp_lat;
        int lat;
        model(o, x, y, r, v, d, exp_lat);
        @(negedge clk);
        check({tag, "_ready_in"}, 64'(ready), 64'(1));
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        while (!valid && lat < 100) begin
            check({tag, "_busy_ready"}, 64'(ready), 64'(0));
            if (noise) begin
                start = 1'($urandom);
                op    = 4'($urandom);
                a     = $urandom;
                b     = $urandom;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_outputs(tag, o, x, y);
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, 64'(valid), 64'(0));
        check({tag, "_hold"}, 64'(result), 64'(r));
    endtask

    logic [3:0]   ro;
    logic [W-1:0] ra, rb;
    int           seen;

    initial begin
        #12;
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_zero", 64'(zero), 64'(1));
        check("rst_ovf", 64'(overflow), 64'(0));
        check("rst_dbz", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h1, 1'b0);

        // Back-to-back SUB then SLT: valid on two consecutive cycles.
        @(negedge clk);
        start = 1'b1; op = 4'd1; a = 32'd5; b = 32'd5;
        @(posedge clk);
        #1;
        op = 4'd6; a = 32'hFFFF_FFFF; b = 32'd1;
        check_outputs("b2b_sub", 4'd1, 32'd5, 32'd5);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_outputs("b2b_slt", 4'd6, 32'hFFFF_FFFF, 32'd1);
        @(posedge clk);
        #1;
        check("b2b_end_valid", 64'(valid), 64'(0));

        do_op("mulhu", 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_op("divu", 4'd10, 32'd100, 32'd7, 1'b1);
        do_op("remu", 4'd11, 32'd100, 32'd7, 1'b0);
        do_op("divu_z", 4'd10, 32'h1234, 32'd0, 1'b0);
        do_op("remu_z", 4'd11, 32'hBEEF, 32'd0, 1'b1);
        do_op("resvd", 4'd13, 32'hFFFF_FFFF, 32'h1, 1'b0);

        // Reset during BUSY aborts a MULU without a valid pulse.
        @(negedge clk);
        start = 1'b1; op = 4'd8; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'(ready), 64'(1));
        check("mid_rst_valid", 64'(valid), 64'(0));
        check("mid_rst_result", 64'(result), 64'(0));
        check("mid_rst_zero", 64'(zero), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) seen++;
        end
        check("mid_rst_no_valid", 64'(seen), 64'(0));
        do_op("post_rst_add", 4'd0, 32'd2, 32'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = ra;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
